student_fir_postproc: RTL and testbench
=======================================

STUDENT_FIR_POSTPROC -- requirements
Module: student_fir_postproc

Interface
REQ-001 SHALL have parameter DATA_SIZE_FIR_OUT, default 32, width of the FIR accumulator result.
REQ-002 SHALL have parameter DATA_SIZE, default 16, width of the codec sample.
REQ-003 SHALL have parameter SHIFT, default 15, arithmetic right-shift applied to the result (Q15 coefficients); legal range 0..DATA_SIZE_FIR_OUT-1.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO depth; power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port valid_strobe_i, input, 1 bit: one-cycle strobe, the FIR result on y_i is valid.
REQ-008 SHALL have port y_i, input, DATA_SIZE_FIR_OUT bits: signed FIR result.
REQ-009 SHALL have port pop_i, input, 1 bit: codec-side consumer takes the head sample this cycle.
REQ-010 SHALL have port sample_o, output, DATA_SIZE bits: signed head-of-FIFO sample, first-word fall-through.
REQ-011 SHALL have port valid_o, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port sat_cnt_o, output, 16 bits: count of saturated samples.
REQ-013 SHALL have port overflow_o, output, 1 bit: sticky flag, a sample was dropped because the FIFO was full.
REQ-014 SHALL have port clear_i, input, 1 bit: clears sat_cnt_o and overflow_o.

Function
REQ-015 SHALL use a 2-stage pipeline. Stage 1 registers (y_i + round constant) >>> SHIFT, computed at DATA_SIZE_FIR_OUT+1 bits so the addition cannot wrap. Stage 2 saturates to DATA_SIZE and pushes the result into the FIFO.
REQ-016 SHALL saturate stage-1 values above 2^(DATA_SIZE-1)-1 to 0x7FFF. Values below -2^(DATA_SIZE-1) saturate to 0x8000. In-range values pass unchanged.
REQ-017 SHALL increment sat_cnt_o on each saturated sample; it holds at 0xFFFF and does not wrap.
REQ-018 SHALL deliver a sample to the FIFO 2 cycles after valid_strobe_i. Into an empty FIFO, valid_o rises on the 2nd rising edge after the strobe.
REQ-019 SHALL accept back-to-back strobes at one per cycle, with no bubbles.
REQ-020 SHALL ignore pop_i while valid_o=0: no pointer change.
REQ-021 On a push into a full FIFO with no pop in the same cycle, SHALL drop the new sample, keep FIFO contents unchanged, and set overflow_o.
REQ-022 SHALL treat a simultaneous push and pop as legal in any state, including full and empty. Occupancy is unchanged (except empty, where it becomes 1 after the pop is ignored), and no overflow is flagged when full.
REQ-023 SHALL use read/write pointers one bit wider than log2(DEPTH) and wrap them modulo 2*DEPTH. Full = MSBs differ and the lower bits are equal.
REQ-024 When clear_i coincides with a saturation or overflow event, SHALL give clear_i priority: counter reads 0, flag reads 0.
REQ-025 SHALL apply rounding constant 0 when SHIFT=0.

Reset
REQ-026 When rst_i=1 at a clock edge, SHALL empty the FIFO, invalidate both pipeline stages, and drive valid_o=0, sample_o=0, sat_cnt_o=0, overflow_o=0.
REQ-027 SHALL discard any sample in flight when reset occurs mid-pipeline; it never reaches the FIFO.
REQ-028 SHALL ignore valid_strobe_i, pop_i and clear_i while rst_i=1.

Configuration
REQ-029 SHALL support macro STUDENT_FIR_POSTPROC_ROUND_EN. When defined, the stage-1 round constant is 2^(SHIFT-1) (round half up). When undefined, the constant is 0 (truncation toward minus infinity); pipeline latency is identical in both cases.

Verification
REQ-030 Rounding test, SHIFT=15: y_i=0x00004000 with one strobe -> sample_o=0x0001 with ROUND_EN defined, 0x0000 without; valid_o rises 2 cycles after the strobe.
REQ-031 Saturation test: y_i=0x7FFFFFFF, then y_i=0x80000000 -> sample_o=0x7FFF, then 0x8000; sat_cnt_o=2.
REQ-032 Overflow test, DEPTH=4: 5 consecutive strobes with values 1..5 (<<15), no pop -> overflow_o=1; pops return 1,2,3,4, then valid_o=0.
REQ-033 Simultaneous test: FIFO full, strobe and pop in the same cycle -> overflow_o stays 0, occupancy stays 4, order is preserved.
REQ-034 Reset test: rst_i=1 one cycle after a strobe -> no sample appears, valid_o=0, and sat_cnt_o=0 on the following cycles.

Source files
------------

// File: rtl/student_fir_postproc.sv
// ----------------------------------------------------------------------------
// student_fir_postproc
//
// Post-processing for a FIR filter result before it is handed to a codec.
// The wide signed accumulator value is rounded (or truncated), shifted down by
// SHIFT and saturated to DATA_SIZE bits. The result is then queued in a small
// first-word-fall-through FIFO that the codec side drains.
//
// Compile-time option:
//   STUDENT_FIR_POSTPROC_ROUND_EN - when defined, stage 1 adds 2^(SHIFT-1)
//                                   before the shift (round half up). When
//                                   undefined, the shift simply truncates
//                                   toward minus infinity. Latency is the
//                                   same either way.
//
// Ports:
//   clk_i          - clock, all logic on the rising edge
//   rst_i          - synchronous active-high reset
//   valid_strobe_i - one-cycle strobe, y_i carries a new FIR result
//   y_i            - signed FIR result, DATA_SIZE_FIR_OUT bits
//   pop_i          - consumer takes the head sample this cycle
//   clear_i        - clears sat_cnt_o and overflow_o
//   sample_o       - signed head-of-FIFO sample (0 while the FIFO is empty)
//   valid_o        - FIFO not empty
//   sat_cnt_o      - saturating count of clipped samples
//   overflow_o     - sticky: a sample was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module student_fir_postproc #(
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int DATA_SIZE         = 16,
    parameter int SHIFT             = 15,
    parameter int DEPTH             = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_strobe_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] y_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output logic [DATA_SIZE-1:0]         sample_o,
    output logic                         valid_o,
    output logic [15:0]                  sat_cnt_o,
    output logic                         overflow_o
);

    localparam int W  = DATA_SIZE_FIR_OUT;
    localparam int AW = $clog2(DEPTH);

`ifdef STUDENT_FIR_POSTPROC_ROUND_EN
    // Half of one output LSB; shifting back down by one makes SHIFT=0 give 0.
    localparam logic [W:0] ROUND_K = ((W+1)'(1) << SHIFT) >> 1;
`else
    localparam logic [W:0] ROUND_K = '0;
`endif

    // Saturation window expressed at the stage-1 width.
    localparam logic signed [W:0] SAT_MAX = {{(W-DATA_SIZE+2){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [W:0] SAT_MIN = {{(W-DATA_SIZE+2){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    // Pipeline and FIFO state.
    logic                    s1_valid_q, s1_valid_d;
    logic signed [W:0]       s1_data_q,  s1_data_d;
    logic [DATA_SIZE-1:0]    mem_q [DEPTH];
    logic [DATA_SIZE-1:0]    mem_d [DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [15:0]             sat_cnt_q, sat_cnt_d;
    logic                    overflow_q, overflow_d;

    logic signed [W:0]       y_ext;
    logic signed [W:0]       sum_s1;
    logic                    sat_hi, sat_lo;
    logic [DATA_SIZE-1:0]    sat_val;
    logic                    fifo_empty, fifo_full;
    logic                    pop_ok, push_ok, ovf_event;

    // Stage 1: widen by one bit so adding the round constant cannot wrap,
    // then arithmetic shift.
    always_comb begin
        y_ext      = {y_i[W-1], y_i};
        sum_s1     = y_ext + $signed(ROUND_K);
        s1_valid_d = valid_strobe_i;
        s1_data_d  = sum_s1 >>> SHIFT;
    end

    // Stage 2 and FIFO: clip the stage-1 value and push it. A pop frees the
    // head slot in the same cycle, so a full FIFO can still accept a push
    // when a pop coincides. Pops on an empty FIFO are ignored.
    always_comb begin
        sat_hi     = s1_data_q > SAT_MAX;
        sat_lo     = s1_data_q < SAT_MIN;
        if (sat_hi) begin
            sat_val = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end else begin
            sat_val = s1_data_q[DATA_SIZE-1:0];
        end

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok     = pop_i && !fifo_empty;
        push_ok    = s1_valid_q && (!fifo_full || pop_ok);
        ovf_event  = s1_valid_q && fifo_full && !pop_ok;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = sat_val;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);

        // clear_i wins over a same-cycle saturation or overflow event.
        sat_cnt_d = sat_cnt_q;
        if (clear_i) begin
            sat_cnt_d = '0;
        end else if (s1_valid_q && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end

        overflow_d = overflow_q;
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (ovf_event) begin
            overflow_d = 1'b1;
        end
    end

    // Control state with synchronous reset; reset also discards anything
    // sitting in stage 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sat_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sat_cnt_q  <= sat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: it is only visible through the pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign valid_o    = !fifo_empty;
    assign sample_o   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign sat_cnt_o  = sat_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_student_fir_postproc.sv
// ----------------------------------------------------------------------------
// tb_student_fir_postproc
//
// Self-checking bench for student_fir_postproc with default parameters.
// A queue-based model predicts the FIFO contents and status outputs from the
// arithmetic definition of the post-processing; a compare process checks the
// DUT against it every cycle, and a directed sequence pins literal values.
// ----------------------------------------------------------------------------
module tb_student_fir_postproc;

    localparam int W     = 32;
    localparam int D     = 16;
    localparam int SH    = 15;
    localparam int DEP   = 4;

`ifdef STUDENT_FIR_POSTPROC_ROUND_EN
    localparam longint RND       = (SH > 0) ? (longint'(1) << (SH - 1)) : 0;
    localparam int     EXP_ROUND = 1;
`else
    localparam longint RND       = 0;
    localparam int     EXP_ROUND = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_strobe_i = 1'b0;
    logic [W-1:0]  y_i = '0;
    logic          pop_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [D-1:0]  sample_o;
    logic          valid_o;
    logic [15:0]   sat_cnt_o;
    logic          overflow_o;

    int compared   = 0;
    int mismatched = 0;

    student_fir_postproc #(
        .DATA_SIZE_FIR_OUT(W),
        .DATA_SIZE(D),
        .SHIFT(SH),
        .DEPTH(DEP)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .valid_strobe_i(valid_strobe_i),
        .y_i(y_i),
        .pop_i(pop_i),
        .clear_i(clear_i),
        .sample_o(sample_o),
        .valid_o(valid_o),
        .sat_cnt_o(sat_cnt_o),
        .overflow_o(overflow_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Shared comparison helper used by both the directed and the model checks.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle worth of inputs, then wait until the next falling edge.
    task automatic applyStimulus(input logic strobe, input logic [W-1:0] y,
                                 input logic pop, input logic clr);
        valid_strobe_i = strobe;
        y_i            = y;
        pop_i          = pop;
        clear_i        = clr;
        @(negedge clk_i);
    endtask

    // Behavioural model: a one-deep stage-1 latch of the scaled value, a
    // queue standing in for the FIFO, and the two status values.
    logic [D-1:0] m_q [$];
    bit           m_s1v   = 0;
    longint       m_s1    = 0;
    int           m_cnt   = 0;
    bit           m_ovf   = 0;
    bit           armed   = 0;
    longint       m_scaled;
    logic [D-1:0] m_val;
    bit           m_sat;
    bit           m_drop;

    // Model update, evaluated at each rising edge with the inputs held
    // since the previous falling edge.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_q.delete();
            m_s1v = 0;
            m_s1  = 0;
            m_cnt = 0;
            m_ovf = 0;
            armed = 1;
        end else begin
            m_sat  = 0;
            m_drop = 0;
            m_val  = '0;
            if (m_s1v) begin
                if (m_s1 > 32767) begin
                    m_val = 16'h7FFF;
                    m_sat = 1;
                end else if (m_s1 < -32768) begin
                    m_val = 16'h8000;
                    m_sat = 1;
                end else begin
                    m_val = 16'(m_s1);
                end
            end
            if (pop_i && m_q.size() > 0) void'(m_q.pop_front());
            if (m_s1v) begin
                if (m_q.size() < DEP) m_q.push_back(m_val);
                else m_drop = 1;
            end
            if (clear_i) begin
                m_cnt = 0;
                m_ovf = 0;
            end else begin
                if (m_sat && m_cnt < 65535) m_cnt++;
                if (m_drop) m_ovf = 1;
            end
            m_scaled = (longint'($signed(y_i)) + RND) >>> SH;
            m_s1v    = valid_strobe_i;
            m_s1     = m_scaled;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        if (armed) begin
            checkOutput("model",
                {30'd0, valid_o, sample_o, sat_cnt_o, overflow_o},
                {30'd0, (m_q.size() > 0), ((m_q.size() > 0) ? m_q[0] : 16'h0000),
                 16'(m_cnt), m_ovf});
        end
    end

    // Directed sequence followed by randomized traffic.
    initial begin
        logic [W-1:0] y_rand;
        logic signed [W-1:0] base;
        int pop_bias;

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset valid", 64'(valid_o), 64'd0);
        checkOutput("reset sample", 64'(sample_o), 64'd0);
        checkOutput("reset sat_cnt", 64'(sat_cnt_o), 64'd0);
        checkOutput("reset overflow", 64'(overflow_o), 64'd0);

        // Rounding: 0x4000 is exactly half an output LSB.
        applyStimulus(1, 32'h0000_4000, 0, 0);
        checkOutput("round valid after 1 edge", 64'(valid_o), 64'd0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("round valid after 2 edges", 64'(valid_o), 64'd1);
        checkOutput("round sample", 64'(sample_o), 64'(EXP_ROUND));
        applyStimulus(0, '0, 1, 0);
        checkOutput("round drained", 64'(valid_o), 64'd0);

        // Saturation at both ends.
        applyStimulus(1, 32'h7FFF_FFFF, 0, 0);
        applyStimulus(1, 32'h8000_0000, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("sat high sample", 64'(sample_o), 64'h7FFF);
        checkOutput("sat count", 64'(sat_cnt_o), 64'd2);
        applyStimulus(0, '0, 1, 0);
        checkOutput("sat low sample", 64'(sample_o), 64'h8000);
        applyStimulus(0, '0, 1, 0);
        checkOutput("sat drained", 64'(valid_o), 64'd0);
        applyStimulus(0, '0, 0, 1);
        checkOutput("clear sat count", 64'(sat_cnt_o), 64'd0);

        // Overflow: five pushes into a four-deep FIFO, no pops.
        for (int k = 1; k <= 5; k++) applyStimulus(1, 32'(k) << 15, 0, 0);
        repeat (2) applyStimulus(0, '0, 0, 0);
        checkOutput("overflow flag", 64'(overflow_o), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("overflow order", 64'(sample_o), 64'(k));
            applyStimulus(0, '0, 1, 0);
        end
        checkOutput("overflow drained", 64'(valid_o), 64'd0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("pop on empty ignored", 64'(valid_o), 64'd0);
        applyStimulus(0, '0, 0, 1);
        checkOutput("clear overflow", 64'(overflow_o), 64'd0);

        // Simultaneous push and pop on a full FIFO.
        for (int k = 10; k <= 13; k++) applyStimulus(1, 32'(k) << 15, 0, 0);
        repeat (2) applyStimulus(0, '0, 0, 0);
        applyStimulus(1, 32'd14 << 15, 0, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("simul no overflow", 64'(overflow_o), 64'd0);
        for (int k = 11; k <= 14; k++) begin
            checkOutput("simul order", 64'(sample_o), 64'(k));
            applyStimulus(0, '0, 1, 0);
        end
        checkOutput("simul drained", 64'(valid_o), 64'd0);

        // Reset one cycle after a strobe discards the in-flight sample.
        applyStimulus(1, 32'h7FFF_FFFF, 0, 0);
        rst_i = 1'b1;
        applyStimulus(1, 32'h0001_0000, 1, 1);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, '0, 0, 0);
            checkOutput("reset flush valid", 64'(valid_o), 64'd0);
            checkOutput("reset flush sat_cnt", 64'(sat_cnt_o), 64'd0);
        end

        // Randomized traffic; pop rate drifts so the FIFO fills and drains.
        for (int c = 0; c < 3000; c++) begin
            pop_bias = ((c / 200) % 2 == 0) ? 4 : 1;
            case ($urandom % 4)
                0: y_rand = $urandom;
                1: begin
                    base   = 32'sh3FFF_8000;
                    y_rand = base + $signed(32'($urandom_range(0, 65536))) - 32'sd32768;
                end
                2: begin
                    base   = 32'shC000_0000;
                    y_rand = base + $signed(32'($urandom_range(0, 65536))) - 32'sd32768;
                end
                default: y_rand = 32'($signed(24'($urandom)));
            endcase
            rst_i = ($urandom % 300 == 0);
            applyStimulus(1'($urandom % 2), y_rand,
                          ($urandom % 5) < pop_bias, ($urandom % 60 == 0));
        end
        rst_i = 1'b0;
        repeat (4) applyStimulus(0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
